// File: rtl/regfile_bypass_sb.sv
// Parametrised register file with optional hard-wired zero register,
// same-cycle write-to-read bypass and a per-register pending scoreboard.
module regfile_bypass_sb #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_READ*AW-1:0]     ReadRegister,
    output logic [NUM_READ*DATA_W-1:0] ReadData,
    output logic [NUM_READ-1:0]        Busy,
    input  logic [AW-1:0]              WriteRegister,
    input  logic [DATA_W-1:0]          WriteData,
    input  logic                       RegWrite,
    input  logic                       IssueValid,
    input  logic [AW-1:0]              IssueRegister,
    output logic [AW:0]                PendingCount
);

    // Zero register exists only when its index lies inside the file.
    localparam logic          ZERO_EN  = (ZERO_REG < NUM_REGS);
    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);
    localparam logic          FWD_EN   = (BYPASS != 0);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [AW:0]         count_nxt;
    logic                wr_en;
    logic                set_en;
    logic                inc;
    logic                dec;

    assign wr_en  = RegWrite && !(ZERO_EN && (WriteRegister == ZERO_IDX));
    assign set_en = IssueValid && !(ZERO_EN && (IssueRegister == ZERO_IDX));

    // Architectural storage; writes to the zero register are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < int'(NUM_REGS); n++) begin
                regs[n] <= '0;
            end
        end else if (wr_en) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    // Scoreboard next state: a new producer (set) wins over a retiring one (clear).
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) begin
            set_vec[IssueRegister] = 1'b1;
        end
        if (RegWrite) begin
            clr_vec[WriteRegister] = 1'b1;
        end
        pending_nxt = (pending & ~clr_vec) | set_vec;
    end

    // Incremental count: +1 for a fresh set, -1 for a clear not cancelled by a re-set.
    always_comb begin
        inc       = set_en && !pending[IssueRegister];
        dec       = RegWrite && pending[WriteRegister]
                    && !(set_en && (IssueRegister == WriteRegister));
        count_nxt = PendingCount + (AW+1)'(inc) - (AW+1)'(dec);
    end

    // Scoreboard and pending count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            PendingCount <= '0;
        end else begin
            pending      <= pending_nxt;
            PendingCount <= count_nxt;
        end
    end

    // Independent combinational read ports with optional write-first forwarding.
    for (genvar i = 0; i < int'(NUM_READ); i++) begin : g_read
        logic [AW-1:0] raddr;
        logic          rd_zero;
        logic          hit;

        assign raddr   = ReadRegister[i*AW +: AW];
        assign rd_zero = ZERO_EN && (raddr == ZERO_IDX);
        assign hit     = FWD_EN && RegWrite && (WriteRegister == raddr);

        assign ReadData[i*DATA_W +: DATA_W] = (reset || rd_zero) ? '0 :
                                              hit ? WriteData : regs[raddr];
        assign Busy[i] = !reset && !rd_zero && pending[raddr] && !hit;
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench: a forwarding instance and a non-forwarding instance share
// all inputs; vectors check combinational reads/busy before each commit edge.
module tb_regfile_bypass_sb;

    logic         clk = 1'b0;
    logic         reset;
    logic [9:0]   read_register;
    logic [4:0]   write_register;
    logic [63:0]  write_data;
    logic         reg_write;
    logic         issue_valid;
    logic [4:0]   issue_register;

    logic [127:0] rdata_b, rdata_n;
    logic [1:0]   busy_b, busy_n;
    logic [5:0]   cnt_b, cnt_n;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_bypass_sb #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .ReadRegister(read_register), .ReadData(rdata_b), .Busy(busy_b),
        .WriteRegister(write_register), .WriteData(write_data), .RegWrite(reg_write),
        .IssueValid(issue_valid), .IssueRegister(issue_register), .PendingCount(cnt_b)
    );

    regfile_bypass_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .ReadRegister(read_register), .ReadData(rdata_n), .Busy(busy_n),
        .WriteRegister(write_register), .WriteData(write_data), .RegWrite(reg_write),
        .IssueValid(issue_valid), .IssueRegister(issue_register), .PendingCount(cnt_n)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] rd0;
        logic [63:0] rd1;
        logic        b0;
        logic        b1;
        logic [5:0]  cnt;
        logic [63:0] nrd0;
        logic        nb0;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    function automatic vec_t mk(input logic rw, input logic [4:0] wr, input logic [63:0] wd,
                                input logic iv, input logic [4:0] ir,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [63:0] rd0, input logic [63:0] rd1,
                                input logic b0, input logic b1, input logic [5:0] cnt,
                                input logic [63:0] nrd0, input logic nb0);
        vec_t v;
        v.rw = rw; v.wr = wr; v.wd = wd; v.iv = iv; v.ir = ir;
        v.ra0 = ra0; v.ra1 = ra1; v.rd0 = rd0; v.rd1 = rd1;
        v.b0 = b0; v.b1 = b1; v.cnt = cnt; v.nrd0 = nrd0; v.nb0 = nb0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [4:0] wr, input logic [63:0] wd,
                         input logic iv, input logic [4:0] ir,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        reg_write      = rw;
        write_register = wr;
        write_data     = wd;
        issue_valid    = iv;
        issue_register = ir;
        read_register  = {ra1, ra0};
    endtask

    localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] Z  = 64'h0;

    initial begin
        vt[0]  = mk(1'b1, 5'd5,  DB,              1'b0, 5'd0,  5'd5,  5'd5,  DB, DB, 1'b0, 1'b0, 6'd0, Z, 1'b0);
        vt[1]  = mk(1'b0, 5'd0,  Z,               1'b0, 5'd0,  5'd5,  5'd0,  DB, Z,  1'b0, 1'b0, 6'd0, DB, 1'b0);
        vt[2]  = mk(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 5'd31, 5'd31, Z, Z, 1'b0, 1'b0, 6'd0, Z, 1'b0);
        vt[3]  = mk(1'b0, 5'd0,  Z,               1'b0, 5'd0,  5'd31, 5'd5,  Z,  DB, 1'b0, 1'b0, 6'd0, Z, 1'b0);
        vt[4]  = mk(1'b0, 5'd0,  Z,               1'b1, 5'd7,  5'd7,  5'd7,  Z,  Z,  1'b0, 1'b0, 6'd0, Z, 1'b0);
        vt[5]  = mk(1'b0, 5'd0,  Z,               1'b0, 5'd0,  5'd7,  5'd5,  Z,  DB, 1'b1, 1'b0, 6'd1, Z, 1'b1);
        vt[6]  = mk(1'b1, 5'd7,  64'h77,          1'b0, 5'd0,  5'd7,  5'd7,  64'h77, 64'h77, 1'b0, 1'b0, 6'd1, Z, 1'b1);
        vt[7]  = mk(1'b0, 5'd0,  Z,               1'b0, 5'd0,  5'd7,  5'd7,  64'h77, 64'h77, 1'b0, 1'b0, 6'd0, 64'h77, 1'b0);
        vt[8]  = mk(1'b0, 5'd0,  Z,               1'b1, 5'd3,  5'd3,  5'd9,  Z,  Z,  1'b0, 1'b0, 6'd0, Z, 1'b0);
        vt[9]  = mk(1'b1, 5'd3,  64'h33,          1'b1, 5'd3,  5'd3,  5'd3,  64'h33, 64'h33, 1'b0, 1'b0, 6'd1, Z, 1'b1);
        vt[10] = mk(1'b1, 5'd3,  64'h34,          1'b1, 5'd9,  5'd3,  5'd9,  64'h34, Z, 1'b0, 1'b0, 6'd1, 64'h33, 1'b1);
        vt[11] = mk(1'b0, 5'd0,  Z,               1'b0, 5'd0,  5'd3,  5'd9,  64'h34, Z, 1'b0, 1'b1, 6'd1, 64'h34, 1'b0);
        vt[12] = mk(1'b1, 5'd12, 64'hC,           1'b0, 5'd0,  5'd12, 5'd9,  64'hC, Z, 1'b0, 1'b1, 6'd1, Z, 1'b0);
        vt[13] = mk(1'b0, 5'd0,  Z,               1'b1, 5'd31, 5'd31, 5'd9,  Z,  Z,  1'b0, 1'b1, 6'd1, Z, 1'b0);
        vt[14] = mk(1'b0, 5'd0,  Z,               1'b0, 5'd0,  5'd31, 5'd12, Z,  64'hC, 1'b0, 1'b0, 6'd1, Z, 1'b0);
        vt[15] = mk(1'b1, 5'd2,  64'h1234,        1'b1, 5'd2,  5'd2,  5'd2,  64'h1234, 64'h1234, 1'b0, 1'b0, 6'd1, Z, 1'b0);
        vt[16] = mk(1'b0, 5'd0,  Z,               1'b1, 5'd4,  5'd2,  5'd4,  64'h1234, Z, 1'b1, 1'b0, 6'd2, 64'h1234, 1'b1);
        vt[17] = mk(1'b0, 5'd0,  Z,               1'b1, 5'd5,  5'd9,  5'd5,  Z,  DB, 1'b1, 1'b0, 6'd3, Z, 1'b1);
        vt[18] = mk(1'b0, 5'd0,  Z,               1'b0, 5'd0,  5'd2,  5'd5,  64'h1234, DB, 1'b1, 1'b1, 6'd4, 64'h1234, 1'b1);

        // Reset with a write pending on the inputs: nothing may leak through.
        reset = 1'b1;
        drive(1'b1, 5'd5, 64'h5555, 1'b1, 5'd5, 5'd5, 5'd6);
        #2;
        chk("rst_rd0", rdata_b[63:0], Z);
        chk("rst_busy", 64'(busy_b), Z);
        repeat (2) @(negedge clk);
        drive(1'b0, 5'd0, Z, 1'b0, 5'd0, 5'd0, 5'd0);
        reset = 1'b0;

        // Every register reads zero on both ports after reset.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, Z, 1'b0, 5'd0, 5'(i), 5'(31 - i));
            #2;
            chk($sformatf("init_rd0[%0d]", i), rdata_b[63:0], Z);
            chk($sformatf("init_rd1[%0d]", i), rdata_b[127:64], Z);
            chk($sformatf("init_busy[%0d]", i), 64'(busy_b), Z);
            chk($sformatf("init_cnt[%0d]", i), 64'(cnt_b), Z);
        end

        // Table vectors: outputs are sampled before the edge that commits the vector.
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(vt[k].rw, vt[k].wr, vt[k].wd, vt[k].iv, vt[k].ir, vt[k].ra0, vt[k].ra1);
            #2;
            chk($sformatf("v%0d_rd0", k), rdata_b[63:0], vt[k].rd0);
            chk($sformatf("v%0d_rd1", k), rdata_b[127:64], vt[k].rd1);
            chk($sformatf("v%0d_busy0", k), 64'(busy_b[0]), 64'(vt[k].b0));
            chk($sformatf("v%0d_busy1", k), 64'(busy_b[1]), 64'(vt[k].b1));
            chk($sformatf("v%0d_cnt", k), 64'(cnt_b), 64'(vt[k].cnt));
            chk($sformatf("v%0d_nb_rd0", k), rdata_n[63:0], vt[k].nrd0);
            chk($sformatf("v%0d_nb_busy0", k), 64'(busy_n[0]), 64'(vt[k].nb0));
            chk($sformatf("v%0d_nb_cnt", k), 64'(cnt_n), 64'(vt[k].cnt));
        end

        // Asynchronous reset between edges with four registers pending.
        @(negedge clk);
        drive(1'b0, 5'd0, Z, 1'b0, 5'd0, 5'd2, 5'd4);
        #1;
        chk("pre_arst_cnt", 64'(cnt_b), 64'd4);
        reset = 1'b1;
        #1;
        chk("arst_cnt", 64'(cnt_b), Z);
        chk("arst_nb_cnt", 64'(cnt_n), Z);
        chk("arst_rd0", rdata_b[63:0], Z);
        chk("arst_busy", 64'(busy_b), Z);
        chk("arst_nb_busy", 64'(busy_n), Z);
        drive(1'b1, 5'd2, 64'hAAAA, 1'b1, 5'd2, 5'd2, 5'd2);
        #1;
        chk("arst_bypass_rd0", rdata_b[63:0], Z);
        @(negedge clk);
        drive(1'b0, 5'd0, Z, 1'b0, 5'd0, 5'd2, 5'd5);
        reset = 1'b0;
        #2;
        chk("post_rst_rd0", rdata_b[63:0], Z);
        chk("post_rst_rd1", rdata_b[127:64], Z);
        chk("post_rst_busy", 64'(busy_b), Z);
        chk("post_rst_cnt", 64'(cnt_b), Z);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
